// File: rtl/sr_sweep_pkg.sv
// Shared definitions for the SR-latch set-pulse-width sweeper.
//   state_e         : sequencer states
//   *_CYC_DEF       : default phase lengths in clock cycles
//   SYNC_STAGES     : depth of the latch_q clock-domain synchronizer
package sr_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_PULSE,
    S_GAP,
    S_SET_PULSE,
    S_SETTLE,
    S_DECIDE,
    S_FINISH
  } state_e;

  localparam int unsigned RESET_CYC_DEF  = 10;
  localparam int unsigned GAP_CYC_DEF    = 3;
  localparam int unsigned SETTLE_CYC_DEF = 150;
  localparam int unsigned SYNC_STAGES    = 2;

endpackage

// File: rtl/sweep_phase_timer.sv
// Loadable down-counter shared by every timed phase of the sweeper.
//   clk, rst  : clock and synchronous active-high reset
//   load      : load load_val this cycle (asserted on phase entry)
//   load_val  : phase length minus one
//   zero      : counter has reached zero (last cycle of the phase)
module sweep_phase_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: give every variable a default at the top of always_comb so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_pw_sweeper.sv
// Sequencer that finds the smallest set-pulse width (in cycles) that flips
// an SR latch, using a decade-refinement search.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : launch a sweep (honoured only when idle)
//   pw_init, inc_init     : first trial width and first increment
//   latch_q               : latch Q, asynchronous to clk
//   latch_set/latch_reset : drives into the latch (never both high)
//   busy, done            : sweep in progress / one-cycle end pulse
//   found, overflow       : sweep outcome, held until next start
//   result_pw, trials     : smallest flipping width, trial count (saturating)
module sr_latch_pw_sweeper
  import sr_sweep_pkg::*;
#(
  parameter int unsigned PW_W       = 16,
  parameter int unsigned RESET_CYC  = RESET_CYC_DEF,
  parameter int unsigned GAP_CYC    = GAP_CYC_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PW_W-1:0] pw_init,
  input  logic [PW_W-1:0] inc_init,
  input  logic            latch_q,
  output logic            latch_set,
  output logic            latch_reset,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic            overflow,
  output logic [PW_W-1:0] result_pw,
  output logic [15:0]     trials
);

  // Timer must hold both the widest pulse and the fixed settle window.
  localparam int unsigned    TMR_W  = (PW_W > 16) ? PW_W : 16;
  localparam logic [PW_W-1:0] DECADE = PW_W'(10);

  state_e                 state_q, state_d;
  logic [PW_W-1:0]        pw_q, pw_d, inc_q, inc_d, result_q, result_d;
  logic [15:0]            trials_q, trials_d;
  logic                   found_q, found_d, overflow_q, overflow_d;
  logic                   done_q, done_d, busy_q, busy_d;
  logic                   set_q, set_d, reset_q, reset_d;
  logic                   q_sample_q, q_sample_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic                   tmr_load, tmr_zero;
  logic [TMR_W-1:0]       tmr_val;

  logic [PW_W+1:0]        pw_minus;
  logic [PW_W:0]          pw_plus;
  logic [PW_W-1:0]        inc_div;

  // pw - 2*inc at PW_W+2 bits: a non-zero top pair means the result went
  // negative (a non-negative result is <= pw and never reaches bit PW_W).
  assign pw_minus = {2'b00, pw_q} - {1'b0, inc_q, 1'b0};
  assign pw_plus  = {1'b0, pw_q} + {1'b0, inc_q};
  assign inc_div  = inc_q / DECADE;
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], latch_q};

  sweep_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    pw_d       = pw_q;
    inc_d      = inc_q;
    result_d   = result_q;
    trials_d   = trials_q;
    found_d    = found_q;
    overflow_d = overflow_q;
    q_sample_d = q_sample_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pw_d       = pw_init;
          inc_d      = inc_init;
          found_d    = 1'b0;
          overflow_d = 1'b0;
          result_d   = '0;
          trials_d   = '0;
          state_d    = (inc_init == '0) ? S_FINISH : S_RST_PULSE;
        end
      end
      S_RST_PULSE: if (tmr_zero) state_d = S_GAP;
      // A zero-width trial bypasses SET_PULSE so latch_set never glitches.
      S_GAP:       if (tmr_zero) state_d = (pw_q == '0) ? S_SETTLE : S_SET_PULSE;
      S_SET_PULSE: if (tmr_zero) state_d = S_SETTLE;
      S_SETTLE: begin
        if (tmr_zero) begin
          q_sample_d = sync_q[SYNC_STAGES-1];
          state_d    = S_DECIDE;
        end
      end
      S_DECIDE: begin
        trials_d = (trials_q == 16'hFFFF) ? trials_q : trials_q + 16'd1;
        if (q_sample_q) begin
          // Flipped: record it, back off two steps and refine one decade.
          found_d  = 1'b1;
          result_d = pw_q;
          pw_d     = (pw_minus[PW_W+1:PW_W] != 2'b00) ? '0 : pw_minus[PW_W-1:0];
          inc_d    = inc_div;
          state_d  = (inc_div == '0) ? S_FINISH : S_RST_PULSE;
        end else if (pw_plus[PW_W]) begin
          overflow_d = 1'b1;
          pw_d       = '1;
          state_d    = S_FINISH;
        end else begin
          pw_d    = pw_plus[PW_W-1:0];
          state_d = (inc_q == '0) ? S_FINISH : S_RST_PULSE;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Timer is reloaded with (length - 1) on entry to each timed phase.
    if (state_d != state_q) begin
      case (state_d)
        S_RST_PULSE: begin tmr_load = 1'b1; tmr_val = TMR_W'(RESET_CYC - 1);  end
        S_GAP:       begin tmr_load = 1'b1; tmr_val = TMR_W'(GAP_CYC - 1);    end
        S_SET_PULSE: begin tmr_load = 1'b1; tmr_val = TMR_W'(pw_q) - TMR_W'(1); end
        S_SETTLE:    begin tmr_load = 1'b1; tmr_val = TMR_W'(SETTLE_CYC - 1); end
        default:     begin tmr_load = 1'b0; tmr_val = '0;                     end
      endcase
    end
  end

  // Drives and busy are registered from the next state so they line up with
  // the phase itself; done is registered from FINISH, so busy falls as done rises.
  always_comb begin
    set_d   = (state_d == S_SET_PULSE);
    reset_d = (state_d == S_RST_PULSE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pw_q       <= '0;
      inc_q      <= '0;
      result_q   <= '0;
      trials_q   <= '0;
      found_q    <= 1'b0;
      overflow_q <= 1'b0;
      q_sample_q <= 1'b0;
      sync_q     <= '0;
      set_q      <= 1'b0;
      reset_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_q       <= pw_d;
      inc_q      <= inc_d;
      result_q   <= result_d;
      trials_q   <= trials_d;
      found_q    <= found_d;
      overflow_q <= overflow_d;
      q_sample_q <= q_sample_d;
      sync_q     <= sync_d;
      set_q      <= set_d;
      reset_q    <= reset_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign latch_set   = set_q;
  assign latch_reset = reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign found       = found_q;
  assign overflow    = overflow_q;
  assign result_pw   = result_q;
  assign trials      = trials_q;

endmodule

// File: doc/sr_latch_pw_sweeper.md
# sr_latch_pw_sweeper

Sequencer that characterises the set-pulse threshold of the SR latch. It drives reset and set pulses into the latch and samples Q after a settle window. A decade-refinement search then finds the smallest set-pulse width, in clock cycles, that flips the latch. It sits between the latch instance and the characterisation harness: it owns the latch's set/reset inputs and reports one result per start.

## Interface
- PW_W, 16, width of pulse-width and increment values
- RESET_CYC, 10, reset-pulse length in cycles
- GAP_CYC, 3, idle cycles between reset release and set rise
- SETTLE_CYC, 150, cycles from set fall to Q sample
- clk  in  1  clock; one clock; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- start  in  1  launch a sweep; sampled only in IDLE
- pw_init  in  PW_W  first trial width, latched at start
- inc_init  in  PW_W  first increment, latched at start
- latch_q  in  1  latch Q output, asynchronous to clk
- latch_set  out  1  set drive to latch
- latch_reset  out  1  reset drive to latch
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at sweep end
- found  out  1  at least one trial flipped the latch; valid with done, held until next start
- overflow  out  1  pw saturated at max; valid with done
- result_pw  out  PW_W  smallest flipping width found; held until next start
- trials  out  16  number of trials executed, saturating

## Operation
- States: IDLE, RST_PULSE, GAP, SET_PULSE, SETTLE, DECIDE, FINISH.
- IDLE: on start, latch pw=pw_init and inc=inc_init, and clear found, overflow, result_pw and trials. If inc_init==0, go to FINISH, otherwise go to RST_PULSE.
- RST_PULSE: latch_reset=1 for RESET_CYC cycles.
- GAP: all drives low for GAP_CYC cycles.
- SET_PULSE: latch_set=1 for exactly pw cycles. If pw==0, SET_PULSE is skipped: zero cycles, no glitch.
- SETTLE: all drives low for SETTLE_CYC cycles.
- latch_q passes through a 2-flop synchronizer. The value sampled at SETTLE exit is q_s.
- DECIDE (1 cycle): trials increments.
  - If q_s=1: found=1, result_pw=pw, pw=max(pw-2*inc, 0), inc=inc/10 (truncating).
  - If q_s=0: pw=pw+inc. If the sum exceeds 2^PW_W-1, set overflow and go to FINISH.
  - Then go to FINISH if inc==0, else go to RST_PULSE.
- FINISH: done=1 for one cycle, then IDLE.
- latch_set and latch_reset are never high in the same cycle.
- start while busy is ignored.

## Timing
- Reset values:
  - Outputs found, overflow, done, busy, latch_set and latch_reset: 0. result_pw and trials: 0.
  - State: IDLE; internal pw and inc: 0.
- All outputs are registered.
- start at edge N gives busy=1 and latch_reset=1 from edge N+1.
- One trial lasts RESET_CYC+GAP_CYC+pw+SETTLE_CYC+1 cycles.
- done is asserted in the cycle after the final DECIDE. busy drops in the same cycle done is asserted.
- inc_init==0: done at edge N+2 with trials=0 and found=0.
- rst mid-sweep: at the next edge, all drives go low, the state returns to IDLE, and every output takes its reset value.
- Width rule: pw-2*inc is computed at PW_W+2 bits, then clamped to 0. pw+inc is computed at PW_W+1 bits and checked for overflow.

## Structure
- Shared package sr_sweep_pkg holds:
  - the state enum;
  - default values for RESET_CYC, GAP_CYC and SETTLE_CYC;
  - the synchronizer depth constant (2).
- One sub-module, sweep_phase_timer: a loadable down-counter with a zero flag. It is shared by all timed states and loaded on state entry.
- The synchronizer is inline.

## Test plan
Every bench uses a behavioural latch model with threshold T: Q goes to 1 iff the set pulse is at least T cycles; reset clears Q.

1. T=1234, pw_init=1000, inc_init=100 -> done with found=1, result_pw=1234, trials=34, overflow=0.
2. T=5, pw_init=0, inc_init=0 -> done two cycles after start, trials=0, found=0, latch_set and latch_reset never asserted.
3. T=3, pw_init=10, inc_init=10 -> first trial passes, pw clamps to 0, then the sweep continues at inc=1 -> result_pw=3, found=1.
4. Model never flips, PW_W=8, pw_init=250, inc_init=10 -> overflow=1, found=0, trials=1, done pulse.
5. Check per trial:
   - latch_reset high exactly 10 cycles;
   - 3-cycle gap;
   - latch_set high exactly pw cycles;
   - sample exactly 150 cycles after set falls;
   - the two drives never overlap.
6. Assert rst during SET_PULSE of trial 2 -> at the next edge latch_set=0, busy=0 and result_pw=0. A later start re-runs scenario 1 with an identical result.
